// File: rtl/gpio_pad_cfg_sequencer.sv
// gpio_pad_cfg_sequencer: serial pad-config shadow register with guarded tri-state commit
// Optional readback of the active config on serial_out: define GPIO_PAD_CFG_READBACK_EN.
module gpio_pad_cfg_sequencer #(
  parameter int          NUM_PADS     = 8,
  parameter int          GUARD_CYCLES = 4,
  parameter logic [12:0] CFG_RESET    = 13'h1009
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  serial_data,
  input  logic                  serial_valid,
  input  logic                  serial_load,
  output logic                  serial_out,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [3*NUM_PADS-1:0] pad_dm,
  output logic [NUM_PADS-1:0]   pad_oe_n,
  output logic [NUM_PADS-1:0]   pad_inp_dis,
  output logic [NUM_PADS-1:0]   pad_ib_mode_sel,
  output logic [NUM_PADS-1:0]   pad_vtrip_sel,
  output logic [NUM_PADS-1:0]   pad_slow,
  output logic [NUM_PADS-1:0]   pad_hld_ovr,
  output logic [NUM_PADS-1:0]   pad_analog_en,
  output logic [NUM_PADS-1:0]   pad_analog_sel,
  output logic [NUM_PADS-1:0]   pad_analog_pol,
  output logic [NUM_PADS-1:0]   pad_hld_h_n
);
  localparam int TOTAL = NUM_PADS * 13;
  localparam int CW    = $clog2(TOTAL + 2);
  localparam int GW    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
`ifdef GPIO_PAD_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, GUARD, COMMIT} state_e;

  state_e              state_q, state_d;
  logic [TOTAL-1:0]    sr_q, sr_d, act_q, act_d, base;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [GW-1:0]       gcnt_q, gcnt_d;
  logic [NUM_PADS-1:0] oe_q, oe_d;
  logic                err_q, err_d, done_q, done_d, busy_q, busy_d, so_q, so_d;

  // next-state: shift/count while collecting, length check on load, guard countdown, commit
  always_comb begin
    base    = (RB && state_q == IDLE) ? act_q : sr_q;
    cnt_inc = (cnt_q == CW'(TOTAL + 1)) ? cnt_q : cnt_q + CW'(1);
    state_d = state_q;
    sr_d    = sr_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    err_d   = err_q;
    so_d    = so_q;
    case (state_q)
      IDLE, SHIFT: begin
        if (serial_valid) begin
          sr_d    = {base[TOTAL-2:0], serial_data};
          cnt_d   = cnt_inc;
          so_d    = RB & base[TOTAL-1];
          state_d = SHIFT;
        end
        if (serial_load) begin
          if (cnt_d == CW'(TOTAL)) begin
            state_d = GUARD;
            gcnt_d  = '0;
          end else begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      GUARD: begin
        state_d = (gcnt_q == GW'(GUARD_CYCLES - 1)) ? COMMIT : GUARD;
        gcnt_d  = gcnt_q + GW'(1);
      end
      default: begin
        act_d   = sr_q;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
    done_d = (state_q == COMMIT);
    busy_d = (state_d == GUARD) || (state_d == COMMIT);
    for (int i = 0; i < NUM_PADS; i++) oe_d[i] = act_d[13*i+3] | (state_d == GUARD);
  end

  // state and registered outputs; reset restores the safe pad configuration immediately
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sr_q    <= '0;
      act_q   <= {NUM_PADS{CFG_RESET}};
      cnt_q   <= '0;
      gcnt_q  <= '0;
      oe_q    <= {NUM_PADS{CFG_RESET[3]}};
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      so_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      oe_q    <= oe_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      so_q    <= so_d;
    end
  end

  assign serial_out = so_q;
  assign cfg_busy   = busy_q;
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;
  assign pad_oe_n   = oe_q;

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    assign pad_dm[3*i+:3]     = act_q[13*i+:3];
    assign pad_inp_dis[i]     = act_q[13*i+4];
    assign pad_ib_mode_sel[i] = act_q[13*i+5];
    assign pad_vtrip_sel[i]   = act_q[13*i+6];
    assign pad_slow[i]        = act_q[13*i+7];
    assign pad_hld_ovr[i]     = act_q[13*i+8];
    assign pad_analog_en[i]   = act_q[13*i+9];
    assign pad_analog_sel[i]  = act_q[13*i+10];
    assign pad_analog_pol[i]  = act_q[13*i+11];
    assign pad_hld_h_n[i]     = act_q[13*i+12];
  end
endmodule

// File: tb/tb_gpio_pad_cfg_sequencer.sv
// tb_gpio_pad_cfg_sequencer: randomized frames checked against a bit-queue model of the pad config
module tb_gpio_pad_cfg_sequencer;
  localparam int NP    = 2;
  localparam int G     = 4;
  localparam int TOTAL = NP * 13;

  logic clk = 1'b0, resetn = 1'b0, serial_data = 1'b0, serial_valid = 1'b0, serial_load = 1'b0;
  logic serial_out, cfg_busy, cfg_done, cfg_err;
  logic [3*NP-1:0] pad_dm;
  logic [NP-1:0] pad_oe_n, pad_inp_dis, pad_ib_mode_sel, pad_vtrip_sel, pad_slow, pad_hld_ovr;
  logic [NP-1:0] pad_analog_en, pad_analog_sel, pad_analog_pol, pad_hld_h_n;

  gpio_pad_cfg_sequencer #(.NUM_PADS(NP), .GUARD_CYCLES(G), .CFG_RESET(13'h1009)) dut (
    .clk(clk), .resetn(resetn), .serial_data(serial_data), .serial_valid(serial_valid),
    .serial_load(serial_load), .serial_out(serial_out), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .pad_dm(pad_dm), .pad_oe_n(pad_oe_n), .pad_inp_dis(pad_inp_dis),
    .pad_ib_mode_sel(pad_ib_mode_sel), .pad_vtrip_sel(pad_vtrip_sel), .pad_slow(pad_slow),
    .pad_hld_ovr(pad_hld_ovr), .pad_analog_en(pad_analog_en), .pad_analog_sel(pad_analog_sel),
    .pad_analog_pol(pad_analog_pol), .pad_hld_h_n(pad_hld_h_n)
  );

  always #5 clk = ~clk;

  wire [13*NP-1:0] pads_obs = {pad_hld_h_n, pad_analog_pol, pad_analog_sel, pad_analog_en, pad_hld_ovr,
                               pad_slow, pad_vtrip_sel, pad_ib_mode_sel, pad_inp_dis, pad_oe_n, pad_dm};

  int pass_cnt = 0, total_cnt = 0;
  logic [12:0] m_act[NP];
  logic [12:0] m_nxt[NP];
  bit m_err;
  int m_cnt;
  bit m_q[$];

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) m_act[i] = 13'h1009;
    m_err = 0;
    m_cnt = 0;
    m_q.delete();
  endfunction

  // a load is good only if exactly one frame's worth of bits arrived since the last count clear;
  // the first bit received belongs to the top bit of the highest pad
  function automatic bit model_load();
    bit acc;
    acc = (m_cnt == TOTAL);
    if (acc) begin
      for (int i = 0; i < NP; i++)
        for (int b = 0; b < 13; b++) m_nxt[i][b] = m_q[TOTAL-1-(13*i+b)];
    end else m_err = 1;
    m_cnt = 0;
    m_q.delete();
    return acc;
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < NP; i++) m_act[i] = m_nxt[i];
    m_err = 0;
  endfunction

  function automatic logic [13*NP-1:0] exp_pads(input bit fo);
    logic [13*NP-1:0] e;
    logic v;
    e = '0;
    for (int i = 0; i < NP; i++)
      for (int b = 0; b < 13; b++) begin
        v = m_act[i][b] | (fo && b == 3);
        if (b < 3) e[3*i+b] = v;
        else e[b*NP+i] = v;
      end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sends v[n-1] first; load rides on the last bit or follows as its own cycle
  task automatic send_bits(input logic [63:0] v, input int n, input bit ld_last, input int gap_max);
    for (int k = n - 1; k >= 0; k--) begin
      repeat ($urandom_range(0, gap_max)) step();
      serial_data  = v[k];
      serial_valid = 1'b1;
      serial_load  = ld_last && (k == 0);
      m_q.push_back(v[k]);
      m_cnt++;
      step();
      serial_valid = 1'b0;
      serial_load  = 1'b0;
    end
    if (!ld_last) begin
      serial_load = 1'b1;
      step();
      serial_load = 1'b0;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({cfg_busy, cfg_done, cfg_err, serial_out, pads_obs} !== {4'b0, exp_pads(0)})
      $display("FAIL reset_state got=%b_%h exp=0000_%h", {cfg_busy, cfg_done, cfg_err, serial_out}, pads_obs, exp_pads(0));
    else pass_cnt++;
    total_cnt++;
    if ({pad_dm, pad_oe_n, pad_hld_h_n} !== {6'b001001, 2'b11, 2'b11})
      $display("FAIL reset_pins got=%b exp=%b", {pad_dm, pad_oe_n, pad_hld_h_n}, {6'b001001, 2'b11, 2'b11});
    else pass_cnt++;
    resetn = 1'b1;
    step();
  endtask

  task automatic test_commit();
    bit acc;
    send_bits(64'h2005806, TOTAL, 1'b1, 0);
    acc = model_load();
    for (int g = 0; g < G; g++) begin
      total_cnt++;
      if ({cfg_busy, cfg_done, cfg_err, pads_obs} !== {2'b10, m_err, exp_pads(1)})
        $display("FAIL commit_guard%0d got=%b_%h exp=10%b_%h", g, {cfg_busy, cfg_done, cfg_err}, pads_obs, m_err, exp_pads(1));
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({cfg_busy, cfg_done, pads_obs} !== {2'b10, exp_pads(0)})
      $display("FAIL commit_phase got=%b_%h exp=10_%h", {cfg_busy, cfg_done}, pads_obs, exp_pads(0));
    else pass_cnt++;
    step();
    if (acc) model_commit();
    total_cnt++;
    if ({cfg_busy, cfg_done, cfg_err, pads_obs} !== {3'b010, exp_pads(0)})
      $display("FAIL commit_done got=%b_%h exp=010_%h", {cfg_busy, cfg_done, cfg_err}, pads_obs, exp_pads(0));
    else pass_cnt++;
    total_cnt++;
    if ({pad_dm, pad_oe_n, pad_hld_h_n, pad_analog_pol} !== {6'b010110, 2'b00, 2'b11, 2'b01})
      $display("FAIL commit_pins got=%b exp=%b", {pad_dm, pad_oe_n, pad_hld_h_n, pad_analog_pol}, {6'b010110, 2'b00, 2'b11, 2'b01});
    else pass_cnt++;
    step();
    total_cnt++;
    if (cfg_done !== 1'b0) $display("FAIL done_pulse got=%b exp=0", cfg_done);
    else pass_cnt++;
  endtask

  task automatic test_readback();
    logic eb;
    for (int k = 0; k < TOTAL; k++) begin
`ifdef GPIO_PAD_CFG_READBACK_EN
      eb = m_act[(TOTAL-1-k)/13][(TOTAL-1-k)%13];
`else
      eb = 1'b0;
`endif
      serial_data  = 1'($urandom_range(0, 1));
      serial_valid = 1'b1;
      serial_load  = (k == TOTAL - 1);
      m_q.push_back(serial_data);
      m_cnt++;
      step();
      serial_valid = 1'b0;
      serial_load  = 1'b0;
      total_cnt++;
      if (serial_out !== eb) $display("FAIL readback_bit%0d got=%b exp=%b", k, serial_out, eb);
      else pass_cnt++;
    end
    if (model_load()) begin
      repeat (G + 1) step();
      model_commit();
    end
    total_cnt++;
    if ({cfg_done, pads_obs} !== {1'b1, exp_pads(0)})
      $display("FAIL readback_commit got=%b_%h exp=1_%h", cfg_done, pads_obs, exp_pads(0));
    else pass_cnt++;
  endtask

  task automatic test_short_frame();
    bit acc;
    send_bits({$urandom, $urandom}, TOTAL - 1, 1'b1, 1);
    acc = model_load();
    total_cnt++;
    if ({acc, cfg_err, cfg_busy, cfg_done, pads_obs} !== {4'b0100, exp_pads(0)})
      $display("FAIL short_err got=%b_%h exp=0100_%h", {acc, cfg_err, cfg_busy, cfg_done}, pads_obs, exp_pads(0));
    else pass_cnt++;
    send_bits({$urandom, $urandom}, TOTAL, 1'b0, 1);
    acc = model_load();
    total_cnt++;
    if ({cfg_busy, cfg_err} !== 2'b11) $display("FAIL short_recover_busy got=%b exp=11", {cfg_busy, cfg_err});
    else pass_cnt++;
    repeat (G + 1) step();
    if (acc) model_commit();
    total_cnt++;
    if ({cfg_done, cfg_err, pads_obs} !== {2'b10, exp_pads(0)})
      $display("FAIL short_recover got=%b_%h exp=10_%h", {cfg_done, cfg_err}, pads_obs, exp_pads(0));
    else pass_cnt++;
  endtask

  task automatic test_long_frame();
    bit acc;
    int busy_seen;
    send_bits({$urandom, $urandom}, TOTAL + 4, 1'b1, 0);
    acc = model_load();
    busy_seen = 0;
    total_cnt++;
    if ({acc, cfg_err, pads_obs} !== {2'b01, exp_pads(0)})
      $display("FAIL long_err got=%b_%h exp=01_%h", {acc, cfg_err}, pads_obs, exp_pads(0));
    else pass_cnt++;
    for (int c = 0; c < G + 2; c++) begin
      busy_seen += int'(cfg_busy);
      step();
    end
    total_cnt++;
    if (busy_seen != 0) $display("FAIL long_no_guard got=%0d busy cycles exp=0", busy_seen);
    else pass_cnt++;
  endtask

  task automatic test_guard_ignore();
    bit acc;
    send_bits({$urandom, $urandom}, TOTAL, 1'b1, 0);
    acc = model_load();
    for (int c = 0; c < G + 1; c++) begin
      serial_data  = 1'($urandom_range(0, 1));
      serial_valid = 1'b1;
      serial_load  = 1'($urandom_range(0, 1));
      step();
    end
    serial_valid = 1'b0;
    serial_load  = 1'b0;
    if (acc) model_commit();
    total_cnt++;
    if ({cfg_done, cfg_busy, pads_obs} !== {2'b10, exp_pads(0)})
      $display("FAIL guard_ignore got=%b_%h exp=10_%h", {cfg_done, cfg_busy}, pads_obs, exp_pads(0));
    else pass_cnt++;
    send_bits({$urandom, $urandom}, TOTAL, 1'b1, 0);
    acc = model_load();
    total_cnt++;
    if ({acc, cfg_busy, cfg_err} !== 3'b110) $display("FAIL guard_no_count got=%b exp=110", {acc, cfg_busy, cfg_err});
    else pass_cnt++;
    step();
    step();
    resetn = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if ({cfg_busy, cfg_done, cfg_err, serial_out, pads_obs} !== {4'b0, exp_pads(0)})
      $display("FAIL reset_mid_guard got=%b_%h exp=0000_%h", {cfg_busy, cfg_done, cfg_err, serial_out}, pads_obs, exp_pads(0));
    else pass_cnt++;
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_random();
    bit acc;
    int n;
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: n = TOTAL;
        3: n = TOTAL - 1;
        4: n = TOTAL + 1;
        default: n = $urandom_range(1, TOTAL + 4);
      endcase
      send_bits({$urandom, $urandom}, n, 1'($urandom_range(0, 1)), 2);
      acc = model_load();
      if (acc) begin
        for (int c = 0; c <= G; c++) begin
          total_cnt++;
          if ({cfg_busy, cfg_done, cfg_err, pads_obs} !== {2'b10, m_err, exp_pads(c < G)})
            $display("FAIL rand%0d_busy%0d got=%b_%h exp=10%b_%h", it, c, {cfg_busy, cfg_done, cfg_err}, pads_obs, m_err, exp_pads(c < G));
          else pass_cnt++;
          step();
        end
        model_commit();
        total_cnt++;
        if ({cfg_busy, cfg_done, cfg_err, pads_obs} !== {3'b010, exp_pads(0)})
          $display("FAIL rand%0d_commit got=%b_%h exp=010_%h", it, {cfg_busy, cfg_done, cfg_err}, pads_obs, exp_pads(0));
        else pass_cnt++;
      end else begin
        total_cnt++;
        if ({cfg_busy, cfg_done, cfg_err, pads_obs} !== {3'b001, exp_pads(0)})
          $display("FAIL rand%0d_err got=%b_%h exp=001_%h", it, {cfg_busy, cfg_done, cfg_err}, pads_obs, exp_pads(0));
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_readback();
    test_short_frame();
    test_long_frame();
    test_guard_ignore();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
